// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: synchronizes board keys/switches, collects operands A and B,
// launches one arithmetic-unit transaction per op key press and drives the indicator value.
module calc_seq_ctrl #(
  parameter int W           = 4,
  parameter int RW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  sw,
  input  logic          k_1,
  input  logic          k_2,
  input  logic          summ4,
  input  logic          vixit5,
  input  logic          umnog7,
  input  logic          delen6,
  output logic          alu_start,
  output logic [1:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic          alu_done,
  input  logic [RW-1:0] alu_result,
  output logic [RW-1:0] disp_value,
  output logic          err,
  output logic [2:0]    state
);

  localparam int NK = 6;
  localparam int NS = W + NK;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_OP   = 3'b010,
    S_EXEC = 3'b011,
    S_RES  = 3'b100,
    S_ERR  = 3'b101
  } state_t;

  // Key bit order: 0 k_1, 1 k_2, 2 summ4, 3 vixit5, 4 umnog7, 5 delen6; switches on top.
  logic [NS-1:0] raw;
  logic [NS-1:0] sync_q [SYNC_STAGES];
  logic [NS-1:0] sync_d [SYNC_STAGES];
  logic [NK-1:0] key_prev_q, key_prev_d;
  logic [NK-1:0] keys_s, press;
  logic [W-1:0]  sw_s;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d, op_key;
  logic [RW-1:0] result_q, result_d, disp_q, disp_d;
  logic          err_q, err_d, start_q, start_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          op_any;

  assign raw    = {sw, delen6, umnog7, vixit5, summ4, k_2, k_1};
  assign keys_s = sync_q[SYNC_STAGES-1][NK-1:0];
  assign sw_s   = sync_q[SYNC_STAGES-1][NS-1:NK];
  assign press  = keys_s & ~key_prev_q;
  assign op_any = |press[5:2];

  always_comb begin
    sync_d[0] = raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Fixed op priority when several op keys rise together: add > sub > mul > div.
  always_comb begin
    if (press[2])      op_key = 2'b00;
    else if (press[3]) op_key = 2'b01;
    else if (press[4]) op_key = 2'b10;
    else               op_key = 2'b11;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    timer_d    = timer_q;
    start_d    = 1'b0;
    key_prev_d = keys_s;

    case (state_q)
      S_A: begin
        if (press[0]) begin
          a_d     = sw_s;
          state_d = S_B;
        end
      end
      S_B: begin
        if (press[0]) begin
          a_d = sw_s;
        end else if (press[1]) begin
          b_d     = sw_s;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (op_any) begin
          op_d = op_key;
          if (op_key == 2'b11 && b_q == '0) begin
            state_d = S_ERR;
          end else begin
            start_d = 1'b1;
            timer_d = '0;
            state_d = S_EXEC;
          end
        end else if (press[0]) begin
          a_d     = sw_s;
          state_d = S_B;
        end
      end
      S_EXEC: begin
        // A done arriving in the final timeout cycle still completes the transaction.
        if (alu_done) begin
          result_d = alu_result;
          state_d  = S_RES;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RES: begin
        if (press[0]) begin
          a_d     = sw_s;
          state_d = S_B;
        end else if (press[1]) begin
          a_d      = '0;
          b_d      = '0;
          op_d     = '0;
          result_d = '0;
          state_d  = S_A;
        end
      end
      S_ERR: begin
        if (press[0] || press[1]) begin
          a_d      = '0;
          b_d      = '0;
          op_d     = '0;
          result_d = '0;
          state_d  = S_A;
        end
      end
      default: state_d = S_A;
    endcase

    err_d = (state_d == S_ERR);

    case (state_d)
      S_A, S_B: disp_d = {{(RW-W){1'b0}}, sw_s};
      S_OP:     disp_d = {{(RW-W){1'b0}}, b_d};
      S_RES:    disp_d = result_d;
      S_ERR:    disp_d = RW'(8'hEE);
      default:  disp_d = disp_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      key_prev_q <= '0;
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      disp_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      timer_q    <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      key_prev_q <= key_prev_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      disp_q     <= disp_d;
      err_q      <= err_d;
      start_q    <= start_d;
      timer_q    <= timer_d;
    end
  end

  assign alu_start  = start_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign disp_value = disp_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: operation table, hand-written corner sequences and random key
// traffic, all cross-checked every cycle against a delay-line + rule-based reference model.
module tb_calc_seq_ctrl;

  localparam int W  = 4;
  localparam int RW = 8;
  localparam int SS = 2;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  sw = '0;
  logic [5:0]    keys = '0;   // 0 k_1, 1 k_2, 2 summ4, 3 vixit5, 4 umnog7, 5 delen6
  logic          alu_done = 1'b0;
  logic [RW-1:0] alu_result = '0;
  logic          alu_start;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b;
  logic [RW-1:0] disp_value;
  logic          err;
  logic [2:0]    state;

  calc_seq_ctrl #(.W(W), .RW(RW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .k_1(keys[0]), .k_2(keys[1]), .summ4(keys[2]), .vixit5(keys[3]),
    .umnog7(keys[4]), .delen6(keys[5]),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .disp_value(disp_value), .err(err), .state(state)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int starts = 0;
  int resp_lat = 3;    // -1 never answer, -2 random latency, else fixed latency
  int spur_cnt = 0;

  // ---------------- reference model ----------------
  logic [9:0]    hq[$];
  int            m_st = 0;
  logic [3:0]    m_a = '0, m_b = '0;
  logic [1:0]    m_op = '0;
  logic [7:0]    m_res = '0, m_disp = '0;
  logic          m_start = 1'b0, m_err = 1'b0;
  int            m_cnt = 0;

  initial begin
    logic [9:0] cur, prv;
    logic [5:0] p;
    logic [3:0] s;
    int ns;
    for (int i = 0; i < SS + 1; i++) hq.push_front('0);
    forever begin
      @(posedge clk);
      if (rst) begin
        m_st = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_disp = '0;
        m_start = 1'b0; m_err = 1'b0; m_cnt = 0;
        hq = {};
        for (int i = 0; i < SS + 1; i++) hq.push_front('0);
      end else begin
        cur = hq[SS-1];
        prv = hq[SS];
        hq.push_front({sw, keys});
        void'(hq.pop_back());
        p = cur[5:0] & ~prv[5:0];
        s = cur[9:6];
        ns = m_st;
        m_start = 1'b0;
        case (m_st)
          0: if (p[0]) begin m_a = s; ns = 1; end
          1: if (p[0]) m_a = s; else if (p[1]) begin m_b = s; ns = 2; end
          2: begin
            if (|p[5:2]) begin
              m_op = p[2] ? 2'd0 : p[3] ? 2'd1 : p[4] ? 2'd2 : 2'd3;
              if (m_op == 2'd3 && m_b == 0) ns = 5;
              else begin ns = 3; m_start = 1'b1; m_cnt = 0; end
            end else if (p[0]) begin m_a = s; ns = 1; end
          end
          3: begin
            if (alu_done) begin
              m_res = alu_result; ns = 4;
              $display("txn: a=%0d b=%0d op=%0d -> result=%0h", m_a, m_b, m_op, alu_result);
            end else begin
              m_cnt++;
              if (m_cnt == TO) ns = 5;
            end
          end
          4: begin
            if (p[0]) begin m_a = s; ns = 1; end
            else if (p[1]) begin m_a = '0; m_b = '0; m_op = '0; m_res = '0; ns = 0; end
          end
          5: if (p[0] | p[1]) begin m_a = '0; m_b = '0; m_op = '0; m_res = '0; ns = 0; end
          default: ns = 0;
        endcase
        case (ns)
          0, 1: m_disp = {4'h0, s};
          2:    m_disp = {4'h0, m_b};
          4:    m_disp = m_res;
          5:    m_disp = 8'hEE;
          default: m_disp = m_disp;
        endcase
        m_st = ns;
        m_err = (ns == 5);
      end
    end
  end

  // ---------------- arithmetic unit responder ----------------
  int         r_cnt = 0;
  bit         r_pend = 1'b0;
  logic [7:0] r_res = '0;
  int         r_seen = 0;
  int         r_lat = 0;

  initial begin
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (alu_start && !r_pend) begin
        r_lat = resp_lat;
        if (r_lat == -2) r_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
        if (r_lat >= 0) begin
          r_pend = 1'b1;
          r_cnt  = r_lat;
          case (alu_op)
            2'd0: r_res = 8'(alu_a) + 8'(alu_b);
            2'd1: r_res = 8'(alu_a) - 8'(alu_b);
            2'd2: r_res = 8'(alu_a) * 8'(alu_b);
            default: r_res = (alu_b != 0) ? 8'(alu_a / alu_b) : 8'h00;
          endcase
        end
      end
      if (r_pend && r_cnt == 0) begin
        alu_done = 1'b1; alu_result = r_res; r_pend = 1'b0;
      end else if (r_pend) begin
        r_cnt--;
      end else if (r_seen != spur_cnt) begin
        r_seen = spur_cnt; alu_done = 1'b1; alu_result = 8'($urandom);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every cycle the main thread waits also compares the DUT against the model.
  task automatic tick();
    logic [25:0] act, exp;
    @(negedge clk);
    act = {state, alu_start, alu_op, alu_a, alu_b, disp_value, err};
    exp = {3'(m_st), m_start, m_op, m_a, m_b, m_disp, m_err};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t: got st=%0d start=%0b op=%0d a=%0h b=%0h disp=%0h err=%0b expected st=%0d start=%0b op=%0d a=%0h b=%0h disp=%0h err=%0b",
               $time, state, alu_start, alu_op, alu_a, alu_b, disp_value, err,
               m_st, m_start, m_op, m_a, m_b, m_disp, m_err);
    end
    if (alu_start) starts++;
  endtask

  task automatic press(input logic [5:0] m, input int hold);
    keys = keys | m;
    repeat (hold) tick();
    keys = keys & ~m;
    repeat (SS + 2) tick();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    keys = '0;
    tick(); tick();
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (state !== s && n < budget) begin tick(); n++; end
    chk(nm, 32'(state), 32'(s));
  endtask

  task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
    sw = a; press(6'b000001, 2);
    sw = b; press(6'b000010, 2);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         key;
    int         lat;
    logic [1:0] exp_op;
    int         exp_starts;
    logic [2:0] exp_state;
    logic [7:0] exp_disp;
    logic       exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    int s0, n;
    vt[0] = '{4'd3,  4'd5, 0, 3, 2'd0, 1, 3'b100, 8'h08, 1'b0};
    vt[1] = '{4'd9,  4'd0, 3, 3, 2'd3, 0, 3'b101, 8'hEE, 1'b1};
    vt[2] = '{4'd12, 4'd3, 1, 1, 2'd1, 1, 3'b100, 8'h09, 1'b0};
    vt[3] = '{4'd2,  4'd7, 1, 2, 2'd1, 1, 3'b100, 8'hFB, 1'b0};
    vt[4] = '{4'd15, 4'd15, 2, 3, 2'd2, 1, 3'b100, 8'hE1, 1'b0};
    vt[5] = '{4'd14, 4'd4, 3, 0, 2'd3, 1, 3'b100, 8'h03, 1'b0};
    vt[6] = '{4'd0,  4'd0, 0, 0, 2'd0, 1, 3'b100, 8'h00, 1'b0};

    // reset state
    tick(); tick();
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_start", 32'(alu_start), 32'h0);
    do_reset();

    // operation table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      resp_lat = vt[i].lat;
      load_ab(vt[i].a, vt[i].b);
      s0 = starts;
      press(6'(1 << (2 + vt[i].key)), 2);
      repeat (15) tick();
      chk("tbl_state", 32'(state), 32'(vt[i].exp_state));
      chk("tbl_disp", 32'(disp_value), 32'(vt[i].exp_disp));
      chk("tbl_err", 32'(err), 32'(vt[i].exp_err));
      chk("tbl_op", 32'(alu_op), 32'(vt[i].exp_op));
      chk("tbl_a", 32'(alu_a), 32'(vt[i].a));
      chk("tbl_b", 32'(alu_b), 32'(vt[i].b));
      chk("tbl_starts", 32'(starts - s0), 32'(vt[i].exp_starts));
      $display("row %0d: a=%0d b=%0d key=%0d -> state=%0d disp=%0h err=%0b", i, vt[i].a, vt[i].b,
               vt[i].key, state, disp_value, err);
    end

    // divide by zero then leave the error state with k_1
    do_reset();
    load_ab(4'd9, 4'd0);
    press(6'b100000, 2);
    chk("div0_err", 32'(err), 32'h1);
    sw = 4'd6;
    press(6'b000001, 2);
    chk("err_exit_state", 32'(state), 32'h0);
    chk("err_exit_err", 32'(err), 32'h0);
    chk("err_exit_a", 32'(alu_a), 32'h0);
    $display("seq err_exit: state=%0d err=%0b", state, err);

    // simultaneous add+div held for 50 cycles
    do_reset();
    resp_lat = 2;
    load_ab(4'd7, 4'd2);
    s0 = starts;
    keys = 6'b100100;
    repeat (50) tick();
    keys = '0;
    repeat (10) tick();
    chk("prio_op", 32'(alu_op), 32'h0);
    chk("prio_starts", 32'(starts - s0), 32'h1);
    chk("prio_disp", 32'(disp_value), 32'h09);
    $display("seq prio: op=%0d starts=%0d disp=%0h", alu_op, starts - s0, disp_value);

    // no done ever: timeout, while the switches toggle
    do_reset();
    resp_lat = -1;
    load_ab(4'd6, 4'd3);
    keys = 6'b010000;
    wait_state(3'b011, 20, "to_enter_exec");
    keys = '0;
    n = 0;
    while (!err && n < TO + 20) begin sw = 4'($urandom); tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'(TO));
    chk("timeout_state", 32'(state), 32'h5);
    chk("exec_hold_a", 32'(alu_a), 32'h6);
    chk("exec_hold_b", 32'(alu_b), 32'h3);
    chk("exec_hold_op", 32'(alu_op), 32'h2);
    $display("seq timeout: err after %0d cycles", n);

    // sub-clock glitch on k_1 never loads; two clean rises load twice
    do_reset();
    sw = 4'd5;
    #1 keys[0] = 1'b1;
    #3 keys[0] = 1'b0;
    repeat (6) tick();
    chk("glitch_state", 32'(state), 32'h0);
    keys[0] = 1'b1; tick(); keys[0] = 1'b0; sw = 4'd10; tick();
    keys[0] = 1'b1; tick(); tick(); keys[0] = 1'b0;
    repeat (6) tick();
    chk("bounce_state", 32'(state), 32'h1);
    chk("bounce_a", 32'(alu_a), 32'hA);
    $display("seq bounce: state=%0d a=%0h", state, alu_a);

    // reset in the middle of a transaction, late done afterwards
    do_reset();
    resp_lat = 4;
    load_ab(4'd4, 4'd4);
    keys = 6'b000100;
    wait_state(3'b011, 20, "abort_enter_exec");
    keys = '0;
    sw = '0;
    #1 rst = 1'b1;
    #1;
    chk("abort_start", 32'(alu_start), 32'h0);
    chk("abort_err", 32'(err), 32'h0);
    chk("abort_state", 32'(state), 32'h0);
    tick(); tick();
    #1 rst = 1'b0;
    repeat (8) tick();
    chk("late_state", 32'(state), 32'h0);
    chk("late_disp", 32'(disp_value), 32'h0);
    chk("late_a", 32'(alu_a), 32'h0);
    chk("late_op", 32'(alu_op), 32'h0);
    $display("seq abort: state=%0d disp=%0h", state, disp_value);

    // random key traffic
    resp_lat = -2;
    for (int it = 0; it < 300; it++) begin
      int r, k;
      logic [5:0] m;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset();
      end else begin
        sw = 4'($urandom);
        k = int'($urandom_range(0, 9));
        if (k < 3) m = 6'b000001;
        else if (k < 5) m = 6'b000010;
        else if (k < 9) m = 6'(1 << (2 + $urandom_range(0, 3)));
        else m = 6'($urandom);
        if ($urandom_range(0, 9) == 0) spur_cnt++;
        press(m, int'($urandom_range(1, 3)));
      end
    end
    repeat (TO + 10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
